// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator.
// FSM state encoding and one-hot {eq,gt,lt} result constants.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_NONE = 3'b000;
  localparam cmp_res_t CMP_EQ   = 3'b100;
  localparam cmp_res_t CMP_GT   = 3'b010;
  localparam cmp_res_t CMP_LT   = 3'b001;

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit eq/gt/lt slice.
// The invert input swaps gt/lt for a two's complement sign bit.
module cmp_bit_slice (
  input  logic a,
  input  logic b,
  input  logic invert,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = invert ? (~a & b) : (a & ~b);
  assign lt = invert ? (a & ~b) : (~a & b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready in and out.
// Define SIGNED_CMP_EN for a two's complement compare.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] MSB = IW'(WIDTH - 1);

  state_t         state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]  idx;
  cmp_res_t       res;
  logic           inv;
  logic           s_eq;
  logic           s_gt;
  logic           s_lt;

`ifdef SIGNED_CMP_EN
  assign inv = (idx == MSB);
`else
  assign inv = 1'b0;
`endif

  cmp_bit_slice u_slice (
    .a      (a_q[idx]),
    .b      (b_q[idx]),
    .invert (inv),
    .eq     (s_eq),
    .gt     (s_gt),
    .lt     (s_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      res       <= CMP_NONE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            idx      <= MSB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          unique case (1'b1)
            !s_eq: begin
              res       <= s_gt ? CMP_GT : CMP_LT;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            s_eq && (idx == '0): begin
              res       <= CMP_EQ;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            default: idx <= idx - 1'b1;
          endcase
        end
        DONE: begin
          if (out_ready) begin
            res       <= CMP_NONE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eq = res[2];
  assign gt = res[1];
  assign lt = res[0];

  // s_lt is implied by !s_eq && !s_gt; kept on the slice for symmetry
  logic unused;
  assign unused = s_lt;

endmodule
